// File: rtl/axi_write_mux_pkg.sv
// rtl/axi_write_mux_pkg.sv - shared types, AXI4 field widths and grant decode for the write mux
package axi_write_mux_pkg;

    localparam int NUM_MASTERS = 4;
    localparam int SEL_W       = 2;
    localparam int LEN_W       = 8;
    localparam int SIZE_W      = 3;
    localparam int BURST_W     = 2;
    localparam int RESP_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] idx;
    } grant_dec_t;

    // Only a clean one-hot grant selects a master; zero or multiple grants are rejected.
    function automatic grant_dec_t decode_grant(input logic [NUM_MASTERS-1:0] g);
        grant_dec_t d;
        d.valid = 1'b1;
        d.idx   = '0;
        case (g)
            4'b0001: d.idx = 2'd0;
            4'b0010: d.idx = 2'd1;
            4'b0100: d.idx = 2'd2;
            4'b1000: d.idx = 2'd3;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/axi_w_beat_counter.sv
// rtl/axi_w_beat_counter.sv - remaining-beat counter that regenerates WLAST from AWLEN
module axi_w_beat_counter
    import axi_write_mux_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    input  logic             dec,
    output logic [LEN_W-1:0] beats,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (reset) begin
            beats <= '0;
        end else if (load) begin
            beats <= len;
        end else if (dec) begin
            beats <= beats - 1'b1;
        end
    end

    assign last = (beats == '0);

endmodule

// File: rtl/axi_write_mux.sv
// rtl/axi_write_mux.sv - latches one granted master per AXI4 write transaction and routes AW/W/B
module axi_write_mux
    import axi_write_mux_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  m0_wgrnt,
    input  logic                  m1_wgrnt,
    input  logic                  m2_wgrnt,
    input  logic                  m3_wgrnt,
    input  logic [ID_W-1:0]       m0_AWID,
    input  logic [ADDR_W-1:0]     m0_AWADDR,
    input  logic [7:0]            m0_AWLEN,
    input  logic [2:0]            m0_AWSIZE,
    input  logic [1:0]            m0_AWBURST,
    input  logic                  m0_AWVALID,
    output logic                  m0_AWREADY,
    input  logic [DATA_W-1:0]     m0_WDATA,
    input  logic [DATA_W/8-1:0]   m0_WSTRB,
    input  logic                  m0_WLAST,
    input  logic                  m0_WVALID,
    output logic                  m0_WREADY,
    output logic [ID_W-1:0]       m0_BID,
    output logic [1:0]            m0_BRESP,
    output logic                  m0_BVALID,
    input  logic                  m0_BREADY,
    input  logic [ID_W-1:0]       m1_AWID,
    input  logic [ADDR_W-1:0]     m1_AWADDR,
    input  logic [7:0]            m1_AWLEN,
    input  logic [2:0]            m1_AWSIZE,
    input  logic [1:0]            m1_AWBURST,
    input  logic                  m1_AWVALID,
    output logic                  m1_AWREADY,
    input  logic [DATA_W-1:0]     m1_WDATA,
    input  logic [DATA_W/8-1:0]   m1_WSTRB,
    input  logic                  m1_WLAST,
    input  logic                  m1_WVALID,
    output logic                  m1_WREADY,
    output logic [ID_W-1:0]       m1_BID,
    output logic [1:0]            m1_BRESP,
    output logic                  m1_BVALID,
    input  logic                  m1_BREADY,
    input  logic [ID_W-1:0]       m2_AWID,
    input  logic [ADDR_W-1:0]     m2_AWADDR,
    input  logic [7:0]            m2_AWLEN,
    input  logic [2:0]            m2_AWSIZE,
    input  logic [1:0]            m2_AWBURST,
    input  logic                  m2_AWVALID,
    output logic                  m2_AWREADY,
    input  logic [DATA_W-1:0]     m2_WDATA,
    input  logic [DATA_W/8-1:0]   m2_WSTRB,
    input  logic                  m2_WLAST,
    input  logic                  m2_WVALID,
    output logic                  m2_WREADY,
    output logic [ID_W-1:0]       m2_BID,
    output logic [1:0]            m2_BRESP,
    output logic                  m2_BVALID,
    input  logic                  m2_BREADY,
    input  logic [ID_W-1:0]       m3_AWID,
    input  logic [ADDR_W-1:0]     m3_AWADDR,
    input  logic [7:0]            m3_AWLEN,
    input  logic [2:0]            m3_AWSIZE,
    input  logic [1:0]            m3_AWBURST,
    input  logic                  m3_AWVALID,
    output logic                  m3_AWREADY,
    input  logic [DATA_W-1:0]     m3_WDATA,
    input  logic [DATA_W/8-1:0]   m3_WSTRB,
    input  logic                  m3_WLAST,
    input  logic                  m3_WVALID,
    output logic                  m3_WREADY,
    output logic [ID_W-1:0]       m3_BID,
    output logic [1:0]            m3_BRESP,
    output logic                  m3_BVALID,
    input  logic                  m3_BREADY,
    output logic [ID_W-1:0]       s_AWID,
    output logic [ADDR_W-1:0]     s_AWADDR,
    output logic [7:0]            s_AWLEN,
    output logic [2:0]            s_AWSIZE,
    output logic [1:0]            s_AWBURST,
    output logic                  s_AWVALID,
    input  logic                  s_AWREADY,
    output logic [DATA_W-1:0]     s_WDATA,
    output logic [DATA_W/8-1:0]   s_WSTRB,
    output logic                  s_WLAST,
    output logic                  s_WVALID,
    input  logic                  s_WREADY,
    input  logic [ID_W-1:0]       s_BID,
    input  logic [1:0]            s_BRESP,
    input  logic                  s_BVALID,
    output logic                  s_BREADY,
    output logic                  busy,
    output logic [1:0]            cur_sel,
    output logic                  wlast_err
);

    logic [NUM_MASTERS-1:0] grnt, awvalid, wlast, wvalid, bready;
    logic [ID_W-1:0]        awid    [NUM_MASTERS];
    logic [ADDR_W-1:0]      awaddr  [NUM_MASTERS];
    logic [LEN_W-1:0]       awlen   [NUM_MASTERS];
    logic [SIZE_W-1:0]      awsize  [NUM_MASTERS];
    logic [BURST_W-1:0]     awburst [NUM_MASTERS];
    logic [DATA_W-1:0]      wdata   [NUM_MASTERS];
    logic [DATA_W/8-1:0]    wstrb   [NUM_MASTERS];

    logic [NUM_MASTERS-1:0] awready, wready, bvalid;
    logic [ID_W-1:0]        bid     [NUM_MASTERS];
    logic [RESP_W-1:0]      bresp   [NUM_MASTERS];

    state_t           state;
    logic [SEL_W-1:0] sel;
    logic [LEN_W-1:0] beats;
    logic             beat_last;
    grant_dec_t       gdec;
    logic             aw_hs, w_hs, b_hs;

    assign grnt    = {m3_wgrnt, m2_wgrnt, m1_wgrnt, m0_wgrnt};
    assign awvalid = {m3_AWVALID, m2_AWVALID, m1_AWVALID, m0_AWVALID};
    assign wlast   = {m3_WLAST, m2_WLAST, m1_WLAST, m0_WLAST};
    assign wvalid  = {m3_WVALID, m2_WVALID, m1_WVALID, m0_WVALID};
    assign bready  = {m3_BREADY, m2_BREADY, m1_BREADY, m0_BREADY};

    assign awid[0] = m0_AWID;       assign awid[1] = m1_AWID;
    assign awid[2] = m2_AWID;       assign awid[3] = m3_AWID;
    assign awaddr[0] = m0_AWADDR;   assign awaddr[1] = m1_AWADDR;
    assign awaddr[2] = m2_AWADDR;   assign awaddr[3] = m3_AWADDR;
    assign awlen[0] = m0_AWLEN;     assign awlen[1] = m1_AWLEN;
    assign awlen[2] = m2_AWLEN;     assign awlen[3] = m3_AWLEN;
    assign awsize[0] = m0_AWSIZE;   assign awsize[1] = m1_AWSIZE;
    assign awsize[2] = m2_AWSIZE;   assign awsize[3] = m3_AWSIZE;
    assign awburst[0] = m0_AWBURST; assign awburst[1] = m1_AWBURST;
    assign awburst[2] = m2_AWBURST; assign awburst[3] = m3_AWBURST;
    assign wdata[0] = m0_WDATA;     assign wdata[1] = m1_WDATA;
    assign wdata[2] = m2_WDATA;     assign wdata[3] = m3_WDATA;
    assign wstrb[0] = m0_WSTRB;     assign wstrb[1] = m1_WSTRB;
    assign wstrb[2] = m2_WSTRB;     assign wstrb[3] = m3_WSTRB;

    assign m0_AWREADY = awready[0]; assign m1_AWREADY = awready[1];
    assign m2_AWREADY = awready[2]; assign m3_AWREADY = awready[3];
    assign m0_WREADY  = wready[0];  assign m1_WREADY  = wready[1];
    assign m2_WREADY  = wready[2];  assign m3_WREADY  = wready[3];
    assign m0_BVALID  = bvalid[0];  assign m1_BVALID  = bvalid[1];
    assign m2_BVALID  = bvalid[2];  assign m3_BVALID  = bvalid[3];
    assign m0_BID     = bid[0];     assign m1_BID     = bid[1];
    assign m2_BID     = bid[2];     assign m3_BID     = bid[3];
    assign m0_BRESP   = bresp[0];   assign m1_BRESP   = bresp[1];
    assign m2_BRESP   = bresp[2];   assign m3_BRESP   = bresp[3];

    assign gdec  = decode_grant(grnt);
    assign aw_hs = s_AWVALID & s_AWREADY;
    assign w_hs  = s_WVALID & s_WREADY;
    assign b_hs  = s_BVALID & s_BREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= ST_IDLE;
            sel       <= '0;
            wlast_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gdec.valid && awvalid[gdec.idx]) begin
                        sel   <= gdec.idx;
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (aw_hs) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_hs) begin
                        if (wlast[sel] != beat_last) wlast_err <= 1'b1;
                        if (beat_last) state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (b_hs) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    axi_w_beat_counter u_beat_counter (
        .clk   (ACLK),
        .reset (ARESET),
        .load  (aw_hs),
        .len   (awlen[sel]),
        .dec   (w_hs & ~beat_last),
        .beats (beats),
        .last  (beat_last)
    );

    // Slave-side payloads are zeroed outside their phase so idle outputs never leak master data.
    always_comb begin
        s_AWID    = '0;
        s_AWADDR  = '0;
        s_AWLEN   = '0;
        s_AWSIZE  = '0;
        s_AWBURST = '0;
        s_AWVALID = 1'b0;
        s_WDATA   = '0;
        s_WSTRB   = '0;
        s_WLAST   = 1'b0;
        s_WVALID  = 1'b0;
        s_BREADY  = 1'b0;
        case (state)
            ST_ADDR: begin
                s_AWID    = awid[sel];
                s_AWADDR  = awaddr[sel];
                s_AWLEN   = awlen[sel];
                s_AWSIZE  = awsize[sel];
                s_AWBURST = awburst[sel];
                s_AWVALID = awvalid[sel];
            end
            ST_DATA: begin
                s_WDATA  = wdata[sel];
                s_WSTRB  = wstrb[sel];
                s_WLAST  = beat_last;
                s_WVALID = wvalid[sel];
            end
            ST_RESP: s_BREADY = bready[sel];
            default: ;
        endcase
    end

    always_comb begin
        awready = '0;
        wready  = '0;
        bvalid  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            bid[i]   = '0;
            bresp[i] = '0;
        end
        case (state)
            ST_ADDR: awready[sel] = s_AWREADY;
            ST_DATA: wready[sel]  = s_WREADY;
            ST_RESP: begin
                bvalid[sel] = s_BVALID;
                bid[sel]    = s_BID;
                bresp[sel]  = s_BRESP;
            end
            default: ;
        endcase
    end

    assign busy    = (state != ST_IDLE);
    assign cur_sel = sel;

endmodule

// File: tb/tb_axi_write_mux.sv
// tb/tb_axi_write_mux.sv - directed scoreboard bench for axi_write_mux
module tb_axi_write_mux;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } aw_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    logic [3:0]       grnt, awvalid, wlast, wvalid, bready;
    logic [3:0]       awready, wready, bvalid;
    logic [3:0][3:0]  awid, wstrb, bid;
    logic [3:0][31:0] awaddr, wdata;
    logic [3:0][7:0]  awlen;
    logic [3:0][2:0]  awsize;
    logic [3:0][1:0]  awburst, bresp;

    logic [3:0]  s_awid, s_bid, s_wstrb;
    logic [31:0] s_awaddr, s_wdata;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst, s_bresp;
    logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        busy, wlast_err;
    logic [1:0]  cur_sel;

    aw_t  aw_q[$];
    w_t   w_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   w_count = 0;
    int   stall_target = 0;
    int   stall_done = 0;
    logic [1:0] slave_bresp = 2'b00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_write_mux #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .ACLK(clk), .ARESET(rst),
        .m0_wgrnt(grnt[0]), .m1_wgrnt(grnt[1]), .m2_wgrnt(grnt[2]), .m3_wgrnt(grnt[3]),
        .m0_AWID(awid[0]), .m0_AWADDR(awaddr[0]), .m0_AWLEN(awlen[0]), .m0_AWSIZE(awsize[0]),
        .m0_AWBURST(awburst[0]), .m0_AWVALID(awvalid[0]), .m0_AWREADY(awready[0]),
        .m0_WDATA(wdata[0]), .m0_WSTRB(wstrb[0]), .m0_WLAST(wlast[0]), .m0_WVALID(wvalid[0]),
        .m0_WREADY(wready[0]), .m0_BID(bid[0]), .m0_BRESP(bresp[0]), .m0_BVALID(bvalid[0]),
        .m0_BREADY(bready[0]),
        .m1_AWID(awid[1]), .m1_AWADDR(awaddr[1]), .m1_AWLEN(awlen[1]), .m1_AWSIZE(awsize[1]),
        .m1_AWBURST(awburst[1]), .m1_AWVALID(awvalid[1]), .m1_AWREADY(awready[1]),
        .m1_WDATA(wdata[1]), .m1_WSTRB(wstrb[1]), .m1_WLAST(wlast[1]), .m1_WVALID(wvalid[1]),
        .m1_WREADY(wready[1]), .m1_BID(bid[1]), .m1_BRESP(bresp[1]), .m1_BVALID(bvalid[1]),
        .m1_BREADY(bready[1]),
        .m2_AWID(awid[2]), .m2_AWADDR(awaddr[2]), .m2_AWLEN(awlen[2]), .m2_AWSIZE(awsize[2]),
        .m2_AWBURST(awburst[2]), .m2_AWVALID(awvalid[2]), .m2_AWREADY(awready[2]),
        .m2_WDATA(wdata[2]), .m2_WSTRB(wstrb[2]), .m2_WLAST(wlast[2]), .m2_WVALID(wvalid[2]),
        .m2_WREADY(wready[2]), .m2_BID(bid[2]), .m2_BRESP(bresp[2]), .m2_BVALID(bvalid[2]),
        .m2_BREADY(bready[2]),
        .m3_AWID(awid[3]), .m3_AWADDR(awaddr[3]), .m3_AWLEN(awlen[3]), .m3_AWSIZE(awsize[3]),
        .m3_AWBURST(awburst[3]), .m3_AWVALID(awvalid[3]), .m3_AWREADY(awready[3]),
        .m3_WDATA(wdata[3]), .m3_WSTRB(wstrb[3]), .m3_WLAST(wlast[3]), .m3_WVALID(wvalid[3]),
        .m3_WREADY(wready[3]), .m3_BID(bid[3]), .m3_BRESP(bresp[3]), .m3_BVALID(bvalid[3]),
        .m3_BREADY(bready[3]),
        .s_AWID(s_awid), .s_AWADDR(s_awaddr), .s_AWLEN(s_awlen), .s_AWSIZE(s_awsize),
        .s_AWBURST(s_awburst), .s_AWVALID(s_awvalid), .s_AWREADY(s_awready),
        .s_WDATA(s_wdata), .s_WSTRB(s_wstrb), .s_WLAST(s_wlast), .s_WVALID(s_wvalid),
        .s_WREADY(s_wready), .s_BID(s_bid), .s_BRESP(s_bresp), .s_BVALID(s_bvalid),
        .s_BREADY(s_bready),
        .busy(busy), .cur_sel(cur_sel), .wlast_err(wlast_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every master other than m must see no READY, no BVALID and zero BID/BRESP.
    task automatic others_check(input int m);
        logic [3:0] mk;
        logic [7:0] side;
        mk = ~(4'b0001 << m);
        side = '0;
        for (int k = 0; k < 4; k++)
            if (k != m) side = side | {2'b00, bid[k], bresp[k]};
        chk("others_ready_bvalid", {52'd0, awready & mk, wready & mk, bvalid & mk}, 64'd0);
        chk("others_bid_bresp", {56'd0, side}, 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cur_sel"}, cur_sel, 0);
        chk({tag, "_wlast_err"}, wlast_err, 0);
        chk({tag, "_s_valids"}, {s_awvalid, s_wvalid, s_bready, s_wlast}, 0);
        chk({tag, "_m_handshake"}, {awready, wready, bvalid}, 0);
    endtask

    // One full master transaction; bad_beat forces WLAST early, rst_beat aborts with reset,
    // sw raises a competing grant on another master from beat 1.
    task automatic txn(input int m, input int len, input int bad_beat, input int rst_beat,
                       input int sw, output int aw_lat, output int total, output int w_cyc);
        aw_t a;
        w_t  w;
        int  c0, n;
        logic hs;
        a.id = 4'($urandom); a.addr = $urandom; a.len = 8'(len);
        a.size = 3'($urandom_range(0, 2)); a.burst = 2'($urandom_range(0, 2));
        aw_q.push_back(a);
        c0 = cyc; aw_lat = -1; total = -1; w_cyc = 0;
        awid[m] = a.id; awaddr[m] = a.addr; awlen[m] = a.len;
        awsize[m] = a.size; awburst[m] = a.burst; awvalid[m] = 1'b1;
        grnt = 4'b0001 << m;
        hs = 1'b0; n = 0;
        while (!hs && n < 20) begin
            @(negedge clk); hs = awready[m]; others_check(m);
            @(posedge clk); #1; n++;
        end
        chk("aw_handshake_seen", hs, 1);
        aw_lat = cyc - c0 - 1;
        awvalid[m] = 1'b0;
        grnt = '0;
        for (int b = 0; b <= len; b++) begin
            w.data = $urandom; w.strb = 4'($urandom_range(1, 15)); w.last = (b == len);
            w_q.push_back(w);
            wdata[m] = w.data; wstrb[m] = w.strb;
            wlast[m] = (b == len) || (b == bad_beat);
            wvalid[m] = 1'b1;
            if (sw >= 0 && b == 1) begin
                grnt = 4'b0001 << sw; awvalid[sw] = 1'b1; awid[sw] = 4'($urandom);
            end
            hs = 1'b0; n = 0;
            while (!hs && n < 20) begin
                @(negedge clk); hs = wready[m]; others_check(m);
                if (sw >= 0) chk("cur_sel_hold", cur_sel, 2'(m));
                if (b == rst_beat) rst = 1'b1;
                @(posedge clk); #1; n++; w_cyc++;
                if (b == rst_beat) begin
                    rst = 1'b0;
                    wvalid[m] = 1'b0; wlast[m] = 1'b0;
                    check_idle_outputs("reset_mid_burst");
                    aw_q.delete(); w_q.delete();
                    return;
                end
            end
            chk("w_handshake_seen", hs, 1);
        end
        wvalid[m] = 1'b0; wlast[m] = 1'b0; bready[m] = 1'b1;
        hs = 1'b0; n = 0;
        while (!hs && n < 20) begin
            @(negedge clk); others_check(m);
            if (bvalid[m]) begin
                hs = 1'b1;
                chk("b_id", bid[m], a.id);
                chk("b_resp", bresp[m], slave_bresp);
            end
            @(posedge clk); #1; n++;
        end
        chk("b_handshake_seen", hs, 1);
        bready[m] = 1'b0;
        total = cyc - c0;
    endtask

    // Slave responder and scoreboard: AW/W observed at the slave port are popped and compared.
    initial begin
        logic aw_hs, w_hs, b_hs, wl, wv, r;
        logic [3:0] cap_id;
        aw_t a;
        w_t  w;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;
        cap_id = '0;
        forever begin
            @(negedge clk);
            aw_hs = s_awvalid && s_awready; w_hs = s_wvalid && s_wready;
            b_hs = s_bvalid && s_bready; wl = s_wlast; wv = s_wvalid;
            if (aw_hs) begin
                if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
                else begin
                    a = aw_q.pop_front();
                    chk("s_awid", s_awid, a.id);
                    chk("s_awaddr", s_awaddr, a.addr);
                    chk("s_awlen", s_awlen, a.len);
                    chk("s_awsize_burst", {s_awsize, s_awburst}, {a.size, a.burst});
                    cap_id = s_awid;
                end
            end
            if (wv) begin
                if (w_q.size() == 0) chk("w_unexpected", 1, 0);
                else begin
                    w = w_q[0];
                    chk("s_wdata", s_wdata, w.data);
                    chk("s_wstrb", s_wstrb, w.strb);
                    chk("s_wlast", s_wlast, w.last);
                    if (w_hs) begin
                        void'(w_q.pop_front());
                        w_count++;
                    end
                end
            end
            @(posedge clk); r = rst; #1;
            if (r) begin
                s_bvalid = 1'b0; s_bid = '0; s_bresp = '0; stall_done = stall_target;
            end else begin
                if (b_hs) begin s_bvalid = 1'b0; s_bid = '0; s_bresp = '0; end
                if (w_hs && wl) begin s_bvalid = 1'b1; s_bid = cap_id; s_bresp = slave_bresp; end
                if (stall_done < stall_target && wv) stall_done++;
            end
            s_wready = (stall_done >= stall_target);
        end
    end

    initial begin
        int lat, tot, wc, n0;
        rst = 1'b1; grnt = '0; awvalid = '0; wlast = '0; wvalid = '0; bready = '0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; wdata = '0; wstrb = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_outputs("reset");

        // Multiple simultaneous grants are ignored.
        grnt = 4'b0011; awvalid = 4'b0011;
        repeat (3) @(posedge clk);
        #1;
        chk("multi_grant_busy", busy, 0);
        chk("multi_grant_awvalid", s_awvalid, 0);
        grnt = '0; awvalid = '0;

        txn(2, 3, -1, -1, -1, lat, tot, wc);
        chk("t1_aw_latency", lat, 1);
        chk("t1_w_cycles", wc, 4);
        chk("t1_total_cycles", tot, 7);
        chk("t1_busy_after", busy, 0);
        chk("t1_wlast_err", wlast_err, 0);

        stall_target = stall_target + 3;
        repeat (2) @(posedge clk);
        #1;
        txn(0, 0, -1, -1, -1, lat, tot, wc);
        chk("t2_w_cycles", wc, 4);
        chk("t2_total_cycles", tot, 7);

        slave_bresp = 2'b10;
        txn(1, 3, -1, -1, 3, lat, tot, wc);
        chk("t3_m1_total", tot, 7);
        txn(3, 2, -1, -1, -1, lat, tot, wc);
        chk("t3_m3_aw_latency", lat, 1);
        chk("t3_m3_total", tot, 6);
        slave_bresp = 2'b00;

        txn(1, 3, 1, -1, -1, lat, tot, wc);
        chk("t4_wlast_err_set", wlast_err, 1);
        chk("t4_total", tot, 7);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_wlast_err_sticky", wlast_err, 1);

        txn(0, 7, -1, 4, -1, lat, tot, wc);
        txn(0, 1, -1, -1, -1, lat, tot, wc);
        chk("t5_fresh_total", tot, 5);
        chk("t5_wlast_err", wlast_err, 0);

        n0 = w_count;
        txn(2, 255, -1, -1, -1, lat, tot, wc);
        chk("t6_w_handshakes", w_count - n0, 256);
        chk("t6_total", tot, 259);
        chk("t6_queue_drained", {aw_q.size(), w_q.size()}, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axi_write_mux.md
# axi_write_mux

Write-channel datapath stage that sits directly downstream of the four-master write arbiter. It consumes the arbiter's one-hot grants and latches the granted master for one full AXI4 write transaction (AW, W burst, B). While latched it routes that master's AW and W channels to the single slave port and returns B to the same master. It regenerates WLAST from AWLEN and flags any master WLAST mismatch.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, write data width; WSTRB is DATA_W/8
- ID_W, 4, transaction ID width
- ACLK  input  1  clock
- ARESET  input  1  reset; one clock, synchronous, active-high
- m0..m3_wgrnt  input  1 each  one-hot write grant from arbiter
- m0..m3_AWID / AWADDR / AWLEN / AWSIZE / AWBURST  input  ID_W / ADDR_W / 8 / 3 / 2 each  master AW payload
- m0..m3_AWVALID  input  1 each; m0..m3_AWREADY  output  1 each
- m0..m3_WDATA / WSTRB / WLAST / WVALID  input  DATA_W / DATA_W/8 / 1 / 1 each; m0..m3_WREADY  output  1 each
- m0..m3_BID / BRESP / BVALID  output  ID_W / 2 / 1 each; m0..m3_BREADY  input  1 each
- s_AWID / AWADDR / AWLEN / AWSIZE / AWBURST / AWVALID  output  slave AW channel; s_AWREADY  input  1
- s_WDATA / WSTRB / WLAST / WVALID  output  slave W channel; s_WREADY  input  1
- s_BID / BRESP / BVALID  input  slave B channel; s_BREADY  output  1
- busy  output  1  high in any state other than IDLE
- cur_sel  output  2  latched master index
- wlast_err  output  1  sticky: master WLAST disagreed with computed last

## Operation
- States: IDLE, ADDR, DATA, RESP. Registers: state, sel[1:0], beats[7:0], wlast_err.
- IDLE: all s_*VALID, s_BREADY, every m*_AWREADY/WREADY/BVALID low. If exactly one grant is high and that master's AWVALID is high: sel <= its index, go ADDR. Zero or multiple grants: stay IDLE.
- ADDR: s_AW* = master[sel] AW*; m[sel]_AWREADY = s_AWREADY. On handshake: beats <= AWLEN, go DATA.
- DATA: s_WDATA/WSTRB/WVALID = master[sel]; s_WLAST = (beats==0); m[sel]_WREADY = s_WREADY. On handshake: if master WLAST != s_WLAST, set wlast_err; if beats==0 go RESP, else beats <= beats-1.
- RESP: m[sel]_BVALID/BID/BRESP = s_B*; s_BREADY = m[sel]_BREADY. On handshake go IDLE.
- Grants are ignored outside IDLE; an arbiter grant change mid-transaction has no effect.
- Non-selected masters always see READY=0, BVALID=0, and BID/BRESP=0.
- wlast_err is cleared only by reset.

## Timing
- Reset values: state IDLE, sel 0, beats 0, wlast_err 0; every output low/zero.
- Grant and AWVALID at cycle t: s_AWVALID is high from t+1. There is one bubble cycle for sel capture.
- Payload paths are combinational from the registered sel. There is no data pipelining, and READY feeds combinationally back to the selected master.
- A burst of N=AWLEN+1 beats with no stalls takes 1 (IDLE) + 1 (ADDR) + N (DATA) + 1 (RESP) cycles, then IDLE again.
- AWLEN 0: a single beat carries s_WLAST=1. AWLEN 255: beats counts down from 255; no wrap, since it exits at 0.
- Back-to-back: a new transaction is accepted no earlier than the cycle after the B handshake, in IDLE.
- Reset asserted mid-transaction: the next edge returns to IDLE and all valids drop that cycle. In-flight beats are lost; the slave must be reset with the block.
- A master dropping AWVALID/WVALID before handshake is passed through unchanged (protocol violation; not masked).

## Structure
- Shared package: state encoding (IDLE=0, ADDR=1, DATA=2, RESP=3), AXI4 field widths (LEN 8, SIZE 3, BURST 2, RESP 2), master count 4.
- One sub-module: axi_w_beat_counter (load AWLEN, decrement on W handshake, output last).
- Master-select muxes are inline case-on-sel logic.

## Test plan
- Grant m2, AWLEN=3, no stalls -> s_AWVALID at t+1, 4 W beats with s_WLAST only on the 4th, BRESP=OKAY returned on m2 only, busy low after 7 cycles.
- Grant m0, AWLEN=0, s_WREADY stalled 3 cycles -> single beat held with s_WLAST=1, WDATA stable, transaction completes after the stall.
- Grant switches m1->m3 during DATA of an m1 burst -> cur_sel stays 1, m3_AWREADY stays 0, and m3 starts only after m1's B handshake.
- m1 asserts WLAST on beat 2 of an AWLEN=3 burst -> wlast_err=1 (sticky), burst still runs 4 beats, response is normal.
- ARESET high during beat 5 of an AWLEN=7 burst -> next cycle: state IDLE, all valids 0, wlast_err 0; a fresh m0 transaction then succeeds.
- AWLEN=255 burst -> exactly 256 W handshakes, s_WLAST only on the last.
